// File: rtl/key_click.sv
// key_click: per-key click classifier fed by debounce press pulses.
// Classifies each press burst as a single or double click within a
// programmable window of WINDOW clock cycles. Defining the macro
// KEY_CLICK_TRIPLE_EN adds a third wait state and drives the triple output.
// Without the macro, triple is tied low and double fires one cycle after
// the second press.
// All event outputs and busy are registered. No combinational path runs
// from key_pulse to any output.

module key_click #(
    parameter int N      = 1,
    parameter int WINDOW = 15_000_000,
    parameter int CW     = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] key_pulse,
    output logic [N-1:0] single,
    output logic [N-1:0] double,
    output logic [N-1:0] triple,
    output logic [N-1:0] busy
);

    // The last counter value inside the click window. The counter starts
    // at 0 in the cycle after a press, so a count of WINDOW-1 marks the
    // final cycle in which a follow-up press is still accepted.
    localparam logic [CW-1:0] LP_CNT_LAST = CW'(WINDOW - 1);

    localparam logic [1:0] LP_IDLE  = 2'd0;
    localparam logic [1:0] LP_WAIT1 = 2'd1;
`ifdef KEY_CLICK_TRIPLE_EN
    localparam logic [1:0] LP_WAIT2 = 2'd2;
`endif

`ifndef KEY_CLICK_TRIPLE_EN
    assign triple = '0;
`endif

    for (genvar g = 0; g < N; g++) begin : g_ch

        logic          w_pulse;
        logic          w_timeout;

        logic [1:0]    r_state;
        logic [1:0]    w_state_nxt;
        logic [CW-1:0] r_cnt;
        logic [CW-1:0] w_cnt_nxt;

        logic          r_single;
        logic          w_single_nxt;
        logic          r_double;
        logic          w_double_nxt;
        logic          r_busy;
        logic          w_busy_nxt;
`ifdef KEY_CLICK_TRIPLE_EN
        logic          r_triple;
        logic          w_triple_nxt;
`endif

        assign w_pulse   = key_pulse[g];
        assign w_timeout = (r_cnt == LP_CNT_LAST);

        // Next-state and event decode for one key channel.
        // A press is tested before the timeout so that a press landing
        // on the last window cycle counts as a click, not a timeout.
        always_comb begin
            w_state_nxt  = r_state;
            w_cnt_nxt    = r_cnt;
            w_single_nxt = 1'b0;
            w_double_nxt = 1'b0;
`ifdef KEY_CLICK_TRIPLE_EN
            w_triple_nxt = 1'b0;
`endif
            case (r_state)
                LP_IDLE: begin
                    w_cnt_nxt = '0;
                    if (w_pulse) begin
                        w_state_nxt = LP_WAIT1;
                    end
                end
                LP_WAIT1: begin
                    if (w_pulse) begin
`ifdef KEY_CLICK_TRIPLE_EN
                        w_state_nxt = LP_WAIT2;
                        w_cnt_nxt   = '0;
`else
                        w_double_nxt = 1'b1;
                        w_state_nxt  = LP_IDLE;
                        w_cnt_nxt    = '0;
`endif
                    end else if (w_timeout) begin
                        w_single_nxt = 1'b1;
                        w_state_nxt  = LP_IDLE;
                        w_cnt_nxt    = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
`ifdef KEY_CLICK_TRIPLE_EN
                LP_WAIT2: begin
                    if (w_pulse) begin
                        w_triple_nxt = 1'b1;
                        w_state_nxt  = LP_IDLE;
                        w_cnt_nxt    = '0;
                    end else if (w_timeout) begin
                        w_double_nxt = 1'b1;
                        w_state_nxt  = LP_IDLE;
                        w_cnt_nxt    = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    w_state_nxt = LP_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
            w_busy_nxt = (w_state_nxt != LP_IDLE);
        end

        // State, counter and registered outputs.
        // Asserting reset discards any pending burst without an event.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_state  <= LP_IDLE;
                r_cnt    <= '0;
                r_single <= 1'b0;
                r_double <= 1'b0;
                r_busy   <= 1'b0;
`ifdef KEY_CLICK_TRIPLE_EN
                r_triple <= 1'b0;
`endif
            end else begin
                r_state  <= w_state_nxt;
                r_cnt    <= w_cnt_nxt;
                r_single <= w_single_nxt;
                r_double <= w_double_nxt;
                r_busy   <= w_busy_nxt;
`ifdef KEY_CLICK_TRIPLE_EN
                r_triple <= w_triple_nxt;
`endif
            end
        end

        assign single[g] = r_single;
        assign double[g] = r_double;
        assign busy[g]   = r_busy;
`ifdef KEY_CLICK_TRIPLE_EN
        assign triple[g] = r_triple;
`endif
    end

endmodule

// File: tb/tb_key_click.sv
// Testbench for key_click with N=2 and WINDOW=8.
// The reference model tracks each key's burst as a click count plus an
// absolute deadline cycle, following the window rules.

module tb_key_click;

    localparam int N      = 2;
    localparam int WINDOW = 8;
    localparam int CW     = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] key_pulse = '0;
    logic [N-1:0] single;
    logic [N-1:0] double;
    logic [N-1:0] triple;
    logic [N-1:0] busy;

    key_click #(.N(N), .WINDOW(WINDOW), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_pulse (key_pulse),
        .single    (single),
        .double    (double),
        .triple    (triple),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int t     = 0;

    // Reference model state per key.
    bit           m_act [N];
    int           m_dl  [N];
    int           m_nck [N];
    logic [N-1:0] e_single, e_double, e_triple, e_busy;

    // Scenario event records (relative cycle; -1 = never).
    int fs0, ls0, fd0, ft0, fs1, nev0, nev1, nb0, fb0;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s t=%0d: observed %b expected %b", tag, t, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            m_act[k] = 1'b0;
            m_dl[k]  = 0;
            m_nck[k] = 0;
        end
        e_single = '0; e_double = '0; e_triple = '0; e_busy = '0;
    endtask

    // Advance the model by one sampled clock edge with press vector p.
    task automatic model_edge(input logic [N-1:0] p);
        e_single = '0; e_double = '0; e_triple = '0;
        for (int k = 0; k < N; k++) begin
            if (m_act[k]) begin
                if (p[k]) begin
                    m_nck[k]++;
`ifdef KEY_CLICK_TRIPLE_EN
                    if (m_nck[k] == 3) begin
                        e_triple[k] = 1'b1;
                        m_act[k]    = 1'b0;
                    end else begin
                        m_dl[k] = t + WINDOW;
                    end
`else
                    e_double[k] = 1'b1;
                    m_act[k]    = 1'b0;
`endif
                end else if (t == m_dl[k]) begin
                    if (m_nck[k] == 1) e_single[k] = 1'b1;
                    else               e_double[k] = 1'b1;
                    m_act[k] = 1'b0;
                end
            end else if (p[k]) begin
                m_act[k] = 1'b1;
                m_nck[k] = 1;
                m_dl[k]  = t + WINDOW;
            end
            e_busy[k] = m_act[k];
        end
    endtask

    task automatic check_all();
        chk("single", single, e_single);
        chk("double", double, e_double);
        chk("triple", triple, e_triple);
        chk("busy",   busy,   e_busy);
    endtask

    // One clock cycle: drive p, sample edge, update model, compare after edge.
    task automatic step(input logic [N-1:0] p);
        key_pulse = p;
        @(posedge clk);
        if (!rst) model_clear();
        else      model_edge(p);
        t++;
        #1;
        check_all();
    endtask

    // Asynchronous reset assertion between edges; outputs must clear at once.
    task automatic assert_reset();
        rst = 1'b0;
        model_clear();
        #1;
        check_all();
    endtask

    // Directed burst: key0 presses at a0/a1/a2, key1 at b0, reset at r0 for 2 cycles.
    task automatic scen(input int a0, input int a1, input int a2, input int b0, input int r0);
        logic [N-1:0] p;
        fs0 = -1; ls0 = -1; fd0 = -1; ft0 = -1; fs1 = -1;
        nev0 = 0; nev1 = 0; nb0 = 0; fb0 = -1;
        for (int c = 0; c < 36; c++) begin
            if (c == r0) assert_reset();
            if (c == r0 + 2) rst = 1'b1;
            p[0] = (c == a0) || (c == a1) || (c == a2);
            p[1] = (c == b0);
            step(p);
            if (single[0]) begin if (fs0 < 0) fs0 = c + 1; ls0 = c + 1; end
            if (double[0] && fd0 < 0) fd0 = c + 1;
            if (triple[0] && ft0 < 0) ft0 = c + 1;
            if (single[1] && fs1 < 0) fs1 = c + 1;
            nev0 += int'(single[0]) + int'(double[0]) + int'(triple[0]);
            nev1 += int'(single[1]) + int'(double[1]) + int'(triple[1]);
            if (busy[0]) begin nb0++; if (fb0 < 0) fb0 = c + 1; end
        end
    endtask

    initial begin
        logic [N-1:0] rp;
        model_clear();
        // Reset held with random presses: outputs stay 0.
        #1;
        check_all();
        for (int i = 0; i < 6; i++) step(N'($urandom));
        #2 rst = 1'b1;
        // Idle after release: no events.
        for (int i = 0; i < 20; i++) step('0);

        // Single click.
        scen(10, -1, -1, -1, -1);
        chk_int("single_cycle", fs0, 19);
        chk_int("single_nodouble", fd0, -1);
        chk_int("single_busy_first", fb0, 11);
        chk_int("single_busy_len", nb0, 8);
        chk_int("single_key1_quiet", nev1, 0);

        // Double on last window cycle.
        scen(10, 18, -1, -1, -1);
`ifdef KEY_CLICK_TRIPLE_EN
        chk_int("edge_double", fd0, 27);
`else
        chk_int("edge_double", fd0, 19);
`endif
        chk_int("edge_nosingle", fs0, -1);

        // Press just after the window: single, then a new burst.
        scen(10, 19, -1, -1, -1);
        chk_int("late_single1", fs0, 19);
        chk_int("late_single2", ls0, 28);
        chk_int("late_events", nev0, 2);

        // Independent keys.
        scen(10, 12, -1, 11, -1);
`ifdef KEY_CLICK_TRIPLE_EN
        chk_int("indep_double0", fd0, 21);
`else
        chk_int("indep_double0", fd0, 13);
`endif
        chk_int("indep_single1", fs1, 20);

        // Reset mid-burst discards the burst.
        scen(10, -1, -1, -1, 14);
        chk_int("rst_mid_events", nev0, 0);

`ifdef KEY_CLICK_TRIPLE_EN
        scen(10, 12, 14, -1, -1);
        chk_int("triple_cycle", ft0, 15);
        scen(10, 12, -1, -1, -1);
        chk_int("triple_double", fd0, 21);
`endif

        // Random presses with occasional resets against the model.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                assert_reset();
                for (int j = 0; j < int'($urandom_range(1, 3)); j++) step(N'($urandom));
                rst = 1'b1;
            end
            for (int k = 0; k < N; k++) rp[k] = ($urandom_range(0, 5) == 0);
            step(rp);
        end
        for (int i = 0; i < 30; i++) step('0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/key_click.md
# key_click

Per-key click classifier sitting directly downstream of `debounce`. Consumes its one-cycle `key_pulse` press events and classifies each press burst as a single or double click (triple with the option below) within a programmable window. Emits one-cycle, registered event pulses to application logic such as mode/menu FSMs.

## Interface
- `N`, 1: number of independent keys; width of every vector port.
- `WINDOW`, 15_000_000: click window in clk cycles (300 ms @ 50 MHz). Legal range: 2 ≤ WINDOW ≤ 2^CW.
- `CW`, 24: window counter width per key.

Ports:
- `clk`  in  1: system clock; all logic on its rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `key_pulse`  in  N: one-cycle press pulses from `debounce`, synchronous to clk.
- `single`  out  N: one-cycle pulse; burst was exactly one press.
- `double`  out  N: one-cycle pulse; burst was two presses.
- `triple`  out  N: one-cycle pulse; burst was three presses (constant 0 unless the option is enabled).
- `busy`  out  N: high while the key's FSM is not in IDLE.

## Operation
- N identical, fully independent channels (generate loop). Each channel has a state register, a CW-bit counter `cnt` and output registers.
- States: IDLE, WAIT1, WAIT2. WAIT2 exists only with the option.
- IDLE: on pulse -> WAIT1, cnt <= 0. Otherwise hold, cnt held at 0.
- WAIT1:
  - On pulse without the option: double <= 1, go to IDLE.
  - On pulse with the option: go to WAIT2, cnt <= 0.
  - No pulse, cnt == WINDOW-1: single <= 1, go to IDLE.
  - Otherwise: cnt <= cnt + 1.
- WAIT2:
  - On pulse: triple <= 1, go to IDLE.
  - No pulse, cnt == WINDOW-1: double <= 1, go to IDLE.
  - Otherwise: cnt <= cnt + 1.
- Pulse and timeout in the same cycle: the pulse wins (counted as a click, no timeout event).
- A pulse arriving in the cycle the FSM returns to IDLE is a new first click.
- Pulses on consecutive cycles each count as a click.
- Event outputs are high for exactly one cycle and are mutually exclusive per key.
- Counter compares only with WINDOW-1 and never wraps.

## Timing
- Reset: all of single, double, triple and busy are 0; every state is IDLE; every cnt is 0. Async assertion clears everything immediately, mid-burst included. The pending burst is discarded with no event.
- First pulse sampled in cycle k -> busy = 1 from cycle k+1.
- Second-click window: cycles k+1 … k+WINDOW inclusive.
- No second click: single = 1 in cycle k+WINDOW+1; busy = 0 in that same cycle.
- Second pulse in cycle m (no option): double = 1 in cycle m+1; busy = 0 in cycle m+1.
- With the option, the double decision waits for WAIT2 timeout: double appears in cycle m+WINDOW+1. A third pulse at cycle p gives triple in cycle p+1.
- All outputs are registered, with no combinational path from key_pulse.

## Configuration
- `KEY_CLICK_TRIPLE_EN` defined:
  - WAIT2 is implemented and `triple` is driven.
  - Double latency becomes the second-press time plus the full window.
- `KEY_CLICK_TRIPLE_EN` undefined:
  - Two-state FSM; `triple` is tied to 0.
  - Double is reported one cycle after the second press.

## Test plan
Bench uses WINDOW=8, N=2, macro off unless stated.
- Reset: hold rst=0 with random key_pulse -> all outputs 0. After release, idle for 20 cycles -> no events.
- Single: pulse key0 at cycle 10 -> single[0]=1 only in cycle 19, busy[0] high in cycles 11–18, key1 silent.
- Double at window edge: pulses at 10 and 18 -> double[0]=1 in cycle 19, no single. Pulses at 10 and 19 -> single at 19, then a new burst whose single falls at cycle 28.
- Independence: key0 pulses at 10 and 12, key1 pulse at 11 -> double[0] at 13, single[1] at 20.
- Reset mid-burst: pulse at 10, rst=0 at 14 for 2 cycles -> no event ever; busy[0]=0 during reset.
- Macro on: pulses at 10, 12, 14 -> triple[0] at 15. Pulses at 10, 12 -> double[0] at 21.
